mimc_round_sched: RTL
=====================

MIMC_ROUND_SCHED -- requirements
Module: mimc_round_sched

Interface
REQ-001 Parameter NUM_ROUNDS, default 91, MiMC round count.
REQ-002 Parameter POW_LATENCY, default 50, clock cycles from pow_base presented to matching pow_result valid.
REQ-003 Parameter N_BITS, default 254, field element width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block idle, request accepted when in_valid & in_ready.
REQ-008 in_x  in  N_BITS  message element.
REQ-009 in_k  in  N_BITS  key element.
REQ-010 pow_base  out  N_BITS  operand driven to the x^7 pipeline.
REQ-011 pow_result  in  N_BITS  x^7 pipeline output.
REQ-012 out_valid  out  1  hash result valid, held until taken.
REQ-013 out_ready  in  1  consumer accepts when out_valid & out_ready.
REQ-014 out_h  out  N_BITS  hash result.

Function
REQ-015 All additions SHALL be mod p, p = 0x30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, as (a+b) computed N_BITS+1 wide, minus p if >= p.
REQ-016 On accept, in_x and in_k SHALL be registered, each reduced by one conditional subtraction of p.
REQ-017 FSM states: IDLE, ADD_K, ADD_C, ISSUE, WAIT, FINAL, DONE.
REQ-018 IDLE: in_ready=1; accept -> ADD_K, round counter r=0.
REQ-019 ADD_K (1 cycle): s = x+k mod p -> ADD_C.
REQ-020 ADD_C (1 cycle): s = s+C[r] mod p -> ISSUE.
REQ-021 ISSUE (1 cycle): pow_base register loaded with s -> WAIT; pow_base SHALL be 0 in every state except ISSUE and its hold during WAIT.
REQ-022 WAIT: down-counter of POW_LATENCY cycles; on expiry x = pow_result; if r = NUM_ROUNDS-1 -> FINAL, else r++ -> ADD_K.
REQ-023 Each round SHALL take exactly POW_LATENCY+3 cycles.
REQ-024 FINAL (1 cycle): out_h = x+k mod p -> DONE.
REQ-025 DONE: out_valid=1, out_h stable; out_valid & out_ready -> IDLE next cycle; in_ready SHALL be 0 in DONE (no overlap).
REQ-026 Accept-to-out_valid latency SHALL be NUM_ROUNDS*(POW_LATENCY+3)+1 cycles with FINAL, NUM_ROUNDS*(POW_LATENCY+3) without.
REQ-027 in_valid while not IDLE SHALL be ignored; out_ready outside DONE SHALL be ignored.

Reset
REQ-028 rst SHALL, at any state including mid-round, force IDLE: in_ready=1, out_valid=0, out_h=0, pow_base=0, r=0, counter=0, x/k/s=0.
REQ-029 pow_result arriving after a mid-operation reset SHALL be discarded.

Configuration
REQ-030 Macro MIMC_FINAL_KEY_ADD_EN defined: FINAL state present, out_h = x_N + k mod p.
REQ-031 Macro undefined: FINAL removed, WAIT of last round goes directly to DONE with out_h = x_N.

Structure
REQ-032 Package mimc_pkg SHALL hold N_BITS, modulus P, NUM_ROUNDS default, round-constant array C[0..NUM_ROUNDS-1] (C[0]=0), and the FSM state enum.
REQ-033 One sub-module mod_add_bn254 (combinational a+b mod p) SHALL be instantiated and reused for ADD_K, ADD_C, FINAL and input reduction via an operand mux.
REQ-034 The x^7 pipeline SHALL remain external; connection via pow_base/pow_result only.

Verification (bench: behavioural x^7 model with configurable delay, NUM_ROUNDS=1, POW_LATENCY=4, macro on unless stated)
REQ-035 x=2, k=0 -> out_h=128 (0x80), out_valid at accept+8.
REQ-036 x=p-1, k=1 -> s=0, out_h=1; x=p+5 (unreduced), k=0 -> out_h = 5^7 = 78125.
REQ-037 Macro off, x=3, k=1 -> out_h = 4^7 = 16384, out_valid at accept+7.
REQ-038 out_ready low 10 cycles after out_valid -> out_h and out_valid stable; in_valid pulses ignored; accept resumes one cycle after handshake.
REQ-039 rst asserted during WAIT -> next cycle in_ready=1, out_valid=0, pow_base=0; late pow_result has no effect; new request x=1, k=0 -> out_h=1.
REQ-040 NUM_ROUNDS=91, POW_LATENCY=50, x=0, k=0 -> out_h equals golden-model MiMC-7 value, out_valid at accept+4824.

Source files
------------

// File: rtl/mimc_pkg.sv
// Shared BN254 MiMC-7 definitions: field width, modulus, round constants, FSM states.
package mimc_pkg;

  localparam int unsigned N_BITS         = 254;
  localparam int unsigned NUM_ROUNDS_DEF = 91;

  localparam logic [255:0] P_WIDE =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [N_BITS-1:0] P = P_WIDE[N_BITS-1:0];

  typedef logic [NUM_ROUNDS_DEF-1:0][N_BITS-1:0] rc_tab_t;

  // Deterministic constants, all far below p; C[0] must stay zero.
  function automatic rc_tab_t gen_round_consts();
    rc_tab_t           t;
    logic [N_BITS-1:0] v;
    t = '0;
    for (int unsigned i = 0; i < NUM_ROUNDS_DEF; i++) begin
      v    = N_BITS'(i);
      t[i] = (v * v * v) + (v << 200);
    end
    return t;
  endfunction

  localparam rc_tab_t C = gen_round_consts();

  typedef enum logic [2:0] {
    StIdle,
    StAddK,
    StAddC,
    StIssue,
    StWait,
    StFinal,
    StDone
  } state_e;

  // Single conditional subtraction; valid for any input below 2p.
  function automatic logic [N_BITS-1:0] mod_reduce(input logic [N_BITS-1:0] v);
    return (v >= P) ? v - P : v;
  endfunction

endpackage

// File: rtl/mod_add_bn254.sv
// Combinational a + b mod p for operands already below p.
module mod_add_bn254 import mimc_pkg::*; (
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  output logic [N_BITS-1:0] o_sum
);

  logic [N_BITS:0] w_raw;

  always_comb begin
    w_raw = {1'b0, i_a} + {1'b0, i_b};
    o_sum = N_BITS'((w_raw >= {1'b0, P}) ? w_raw - {1'b0, P} : w_raw);
  end

endmodule

// File: rtl/mimc_round_sched.sv
// MiMC-7 round scheduler around an external x^7 pipeline with fixed latency.
// Define MIMC_FINAL_KEY_ADD_EN to add the closing key addition (FINAL state).
module mimc_round_sched #(
  parameter int unsigned NUM_ROUNDS  = mimc_pkg::NUM_ROUNDS_DEF,
  parameter int unsigned POW_LATENCY = 50,
  parameter int unsigned N_BITS      = mimc_pkg::N_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_x,
  input  logic [N_BITS-1:0] in_k,
  output logic [N_BITS-1:0] pow_base,
  input  logic [N_BITS-1:0] pow_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_h
);
  import mimc_pkg::*;

  localparam int unsigned RndW   = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam int unsigned CntW   = (POW_LATENCY > 1) ? $clog2(POW_LATENCY) : 1;
  localparam int unsigned RcIdxW = $clog2(NUM_ROUNDS_DEF);

`ifdef MIMC_FINAL_KEY_ADD_EN
  localparam state_e StAfterLast = StFinal;
`else
  localparam state_e StAfterLast = StDone;
`endif

  state_e            r_state;
  state_e            w_state_nxt;
  logic [N_BITS-1:0] r_x;
  logic [N_BITS-1:0] r_k;
  logic [N_BITS-1:0] r_s;
  logic [N_BITS-1:0] r_pow_base;
  logic [N_BITS-1:0] r_out_h;
  logic [RndW-1:0]   r_round;
  logic [CntW-1:0]   r_cnt;

  logic [N_BITS-1:0] w_add_a;
  logic [N_BITS-1:0] w_add_b;
  logic [N_BITS-1:0] w_add_sum;
  logic [RcIdxW-1:0] w_rc_idx;
  logic              w_last;

  assign w_rc_idx = RcIdxW'(r_round);
  assign w_last   = (r_round == RndW'(NUM_ROUNDS - 1));

  mod_add_bn254 u_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .o_sum (w_add_sum)
  );

  // One adder serves input reduction (x + 0), key add, constant add and final add.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    unique case (r_state)
      StIdle: begin
        w_add_a = in_x;
        w_add_b = '0;
      end
      StAddK, StFinal: begin
        w_add_a = r_x;
        w_add_b = r_k;
      end
      StAddC: begin
        w_add_a = r_s;
        w_add_b = C[w_rc_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = (r_state == StIdle);
    out_valid   = (r_state == StDone);
    pow_base    = r_pow_base;
    out_h       = r_out_h;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_nxt = StAddK;
      StAddK:  w_state_nxt = StAddC;
      StAddC:  w_state_nxt = StIssue;
      StIssue: w_state_nxt = StWait;
      StWait:  if (r_cnt == '0) w_state_nxt = w_last ? StAfterLast : StAddK;
      StFinal: w_state_nxt = StDone;
      StDone:  if (out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // pow_base is loaded with the ADD_C result so it is already presented during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_k        <= '0;
      r_s        <= '0;
      r_pow_base <= '0;
      r_out_h    <= '0;
      r_round    <= '0;
      r_cnt      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_x     <= w_add_sum;
            r_k     <= mod_reduce(in_k);
            r_round <= '0;
          end
        end
        StAddK: r_s <= w_add_sum;
        StAddC: begin
          r_s        <= w_add_sum;
          r_pow_base <= w_add_sum;
        end
        StIssue: r_cnt <= CntW'(POW_LATENCY - 1);
        StWait: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CntW'(1);
          end else begin
            r_pow_base <= '0;
            r_x        <= pow_result;
            if (!w_last) r_round <= r_round + RndW'(1);
`ifndef MIMC_FINAL_KEY_ADD_EN
            if (w_last) r_out_h <= pow_result;
`endif
          end
        end
        StFinal: r_out_h <= w_add_sum;
        default: ;
      endcase
    end
  end

endmodule
